// File: rtl/gtech_rst_sync_stretch_if.sv
// gtech_rst_sync_stretch_if
//   Groups the soft-reset request and the conditioned reset outputs of
//   gtech_rst_sync_stretch. The clock (CP) and raw reset (CD) are not part of
//   this bundle; they stay plain ports on the module.
//
//   Signals:
//     SR        soft-reset request, synchronous to CP, active-high
//     RN        conditioned reset, active-low, driven straight from a flop
//     RDY       one-cycle pulse on the edge RN deasserts
//     BUSY      high whenever the conditioner is not in RUN
//     state_dbg current FSM state (HOLD=0, COUNT=1, RUN=2), for observation
//
//   Handshake: SR is sampled on every rising CP edge; there is no ready/valid
//   exchange. RDY is the only completion indication: it is high for exactly
//   the one cycle that follows the edge on which RN rose.
//
//   Modports:
//     master  the requester side (drives SR, observes the rest)
//     slave   the conditioner side (samples SR, drives the rest)
interface gtech_rst_sync_stretch_if;
  logic       SR;
  logic       RN;
  logic       RDY;
  logic       BUSY;
  logic [1:0] state_dbg;

  modport master (
    output SR,
    input  RN,
    input  RDY,
    input  BUSY,
    input  state_dbg
  );

  modport slave (
    input  SR,
    output RN,
    output RDY,
    output BUSY,
    output state_dbg
  );
endinterface

// File: rtl/gtech_rst_sync_stretch.sv
// gtech_rst_sync_stretch
//   Reset conditioner for the CP domain. A raw asynchronous active-low reset
//   (CD) is turned into a clean active-low reset (RN) that asserts
//   immediately and releases synchronously, STRETCH edges after the
//   synchronized release. A synchronous soft-reset request (SR) restarts the
//   stretch without disturbing the synchronizer.
//
//   Parameters:
//     SYNC_STAGES  synchronizer flop count (>= 2)
//     STRETCH      CP edges RN is held low after synchronized release (>= 1)
//
//   Ports:
//     CP  input   clock, rising edge
//     CD  input   raw reset, asynchronous, active-low
//     rs  slave   SR in; RN, RDY, BUSY, state_dbg out
module gtech_rst_sync_stretch #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 4
) (
  input  logic                    CP,
  input  logic                    CD,
  gtech_rst_sync_stretch_if.slave rs
);

  localparam int CNT_W = (STRETCH + 1 > 2) ? $clog2(STRETCH + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH - 1);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    COUNT = 2'd1,
    RUN   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rn_q, rn_d;
  logic                   rdy_q, rdy_d;

  // The first stage's D is tied high: after CD releases, a 1 simply ripples
  // through the chain. SR deliberately has no effect here.
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rn_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rn_q    <= rn_d;
      rdy_q   <= rdy_d;
    end
  end

  // RDY defaults low so it can only be high for the single cycle after the
  // COUNT->RUN edge. SR overrides everything, including the terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rn_d    = rn_q;
    rdy_d   = 1'b0;

    if (rs.SR) begin
      state_d = HOLD;
      cnt_d   = '0;
      rn_d    = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          rn_d = 1'b0;
          if (sync_out) begin
            state_d = COUNT;
            cnt_d   = '0;
          end
        end
        COUNT: begin
          rn_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            // cnt is left at its terminal value; it never goes beyond it.
            state_d = RUN;
            rn_d    = 1'b1;
            rdy_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          rn_d = 1'b1;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          rn_d    = 1'b0;
        end
      endcase
    end
  end

  assign rs.RN        = rn_q;
  assign rs.RDY       = rdy_q;
  assign rs.BUSY      = (state_q != RUN);
  assign rs.state_dbg = state_q;

endmodule
